// File: rtl/judge_meter_if.sv
// Bundle of judge strobes, beam position and meter outputs between the arrow
// judges / video mux (master) and the life/score meter (slave).
interface judge_meter_if #(
    parameter int CORDW   = 10,
    parameter int LANES   = 4,
    parameter int LIFE_W  = 10,
    parameter int SCORE_W = 20,
    parameter int COMBO_W = 8
);
    logic                 clear_i;
    logic [4*LANES-1:0]   judge_i;
    logic [CORDW-1:0]     sx_i;
    logic [CORDW-1:0]     sy_i;
    logic [LIFE_W-1:0]    life_o;
    logic [SCORE_W-1:0]   score_o;
    logic [COMBO_W-1:0]   combo_o;
    logic [COMBO_W-1:0]   max_combo_o;
    logic                 failed_o;
    logic                 life_bar_o;

    modport slave (
        input  clear_i, judge_i, sx_i, sy_i,
        output life_o, score_o, combo_o, max_combo_o, failed_o, life_bar_o
    );

    modport master (
        output clear_i, judge_i, sx_i, sy_i,
        input  life_o, score_o, combo_o, max_combo_o, failed_o, life_bar_o
    );
endinterface

// File: rtl/judge_meter.sv
// Life/score meter: edge-detects per-lane judge strobes, applies grade-weighted
// life gain / miss penalty, tracks score and combo, and draws the life bar pixel.
module judge_meter #(
    parameter int CORDW       = 10,
    parameter int LANES       = 4,
    parameter int LIFE_W      = 10,
    parameter int LIFE_MAX    = 320,
    parameter int LIFE_INIT   = 160,
    parameter int W_PERFECT   = 8,
    parameter int W_GREAT     = 5,
    parameter int W_GOOD      = 2,
    parameter int W_MISS      = 20,
    parameter int PTS_PERFECT = 100,
    parameter int PTS_GREAT   = 50,
    parameter int PTS_GOOD    = 20,
    parameter int SCORE_W     = 20,
    parameter int COMBO_W     = 8,
    parameter int BAR_X0      = 10,
    parameter int BAR_X1      = 20,
    parameter int BAR_Y_BOT   = 330
) (
    input  logic          clk_i,
    input  logic          reset_i,
    judge_meter_if.slave  bus
);
    localparam logic [63:0] SCORE_SAT = (64'd1 << SCORE_W) - 64'd1;
    localparam logic [63:0] COMBO_SAT = (64'd1 << COMBO_W) - 64'd1;

    logic [4*LANES-1:0] r_judge_q;
    logic [LIFE_W-1:0]  r_life;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;
    logic [COMBO_W-1:0] r_max_combo;
    logic               r_failed;

    logic [31:0]        w_hits;
    logic [31:0]        w_misses;
    logic [31:0]        w_gain;
    logic [31:0]        w_pts;
    logic signed [31:0] w_life_sum;
    logic [LIFE_W-1:0]  w_life_next;
    logic [63:0]        w_score_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic [63:0]        w_combo_sum;
    logic [COMBO_W-1:0] w_combo_next;
    logic [COMBO_W-1:0] w_max_next;

    // A lane fires only on a 0 -> one-hot transition; multi-bit nibbles are
    // swallowed but still land in r_judge_q so they cannot fire later.
    always_comb begin
        w_hits   = '0;
        w_misses = '0;
        w_gain   = '0;
        w_pts    = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_judge_q[4*k +: 4] == 4'd0) begin
                case (bus.judge_i[4*k +: 4])
                    4'b1000: begin
                        w_hits = w_hits + 32'd1;
                        w_gain = w_gain + 32'(W_PERFECT);
                        w_pts  = w_pts + 32'(PTS_PERFECT);
                    end
                    4'b0100: begin
                        w_hits = w_hits + 32'd1;
                        w_gain = w_gain + 32'(W_GREAT);
                        w_pts  = w_pts + 32'(PTS_GREAT);
                    end
                    4'b0010: begin
                        w_hits = w_hits + 32'd1;
                        w_gain = w_gain + 32'(W_GOOD);
                        w_pts  = w_pts + 32'(PTS_GOOD);
                    end
                    4'b0001: w_misses = w_misses + 32'd1;
                    default: ;
                endcase
            end
        end
    end

    // Gain and loss net out in a wide signed sum before clamping.
    always_comb begin
        w_life_sum = $signed(32'(r_life)) + $signed(w_gain)
                   - $signed(w_misses * 32'(W_MISS));
        if (w_life_sum < 0)
            w_life_next = '0;
        else if (w_life_sum > LIFE_MAX)
            w_life_next = LIFE_W'(LIFE_MAX);
        else
            w_life_next = LIFE_W'(w_life_sum);
    end

    always_comb begin
        w_score_sum  = 64'(r_score) + 64'(w_pts);
        w_score_next = (w_score_sum > SCORE_SAT) ? SCORE_W'(SCORE_SAT)
                                                 : SCORE_W'(w_score_sum);
        w_combo_sum  = 64'(r_combo) + 64'(w_hits);
        if (w_misses != 32'd0)
            w_combo_next = '0;
        else if (w_combo_sum > COMBO_SAT)
            w_combo_next = COMBO_W'(COMBO_SAT);
        else
            w_combo_next = COMBO_W'(w_combo_sum);
        w_max_next = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_judge_q   <= '0;
            r_life      <= LIFE_W'(LIFE_INIT);
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_failed    <= 1'b0;
        end else if (bus.clear_i) begin
            r_judge_q   <= '0;
            r_life      <= LIFE_W'(LIFE_INIT);
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_failed    <= 1'b0;
        end else begin
            r_judge_q <= bus.judge_i;
            if (!r_failed) begin
                r_life      <= w_life_next;
                r_score     <= w_score_next;
                r_combo     <= w_combo_next;
                r_max_combo <= w_max_next;
                r_failed    <= (w_life_next == '0);
            end
        end
    end

    logic               w_in_x;
    logic               w_in_y;
    logic signed [31:0] w_sy;
    logic signed [31:0] w_bar_top;

    // Bar grows upward from BAR_Y_BOT; life rows are lit, life = 0 lights none.
    assign w_sy      = $signed(32'(bus.sy_i));
    assign w_bar_top = BAR_Y_BOT - $signed(32'(r_life));
    assign w_in_x    = (32'(bus.sx_i) >= 32'(BAR_X0)) && (32'(bus.sx_i) <= 32'(BAR_X1));
    assign w_in_y    = (w_sy <= BAR_Y_BOT) && (w_sy > w_bar_top);

    assign bus.life_o      = r_life;
    assign bus.score_o     = r_score;
    assign bus.combo_o     = r_combo;
    assign bus.max_combo_o = r_max_combo;
    assign bus.failed_o    = r_failed;
    assign bus.life_bar_o  = w_in_x && w_in_y;
endmodule

// File: tb/tb_judge_meter.sv
// Self-checking bench for judge_meter: directed vector table, corner-case
// sequences and randomized strobes against an event-level reference model.
module tb_judge_meter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    judge_meter_if u_if ();
    judge_meter dut (.clk_i(clk), .reset_i(rst), .bus(u_if));

    int checks   = 0;
    int failures = 0;

    int m_life, m_score, m_combo, m_max;
    bit m_failed;
    logic [15:0] m_prev;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_life = 160; m_score = 0; m_combo = 0; m_max = 0;
        m_failed = 0; m_prev = '0;
    endtask

    task automatic model_clk(input bit clr, input logic [15:0] j);
        int h, m, g, p, nl;
        logic [3:0] nib;
        if (clr) begin
            model_reset();
            return;
        end
        h = 0; m = 0; g = 0; p = 0;
        for (int k = 0; k < 4; k++) begin
            nib = j[4*k +: 4];
            if (m_prev[4*k +: 4] == 4'd0 && $countones(nib) == 1) begin
                if (nib[3]) begin h++; g += 8; p += 100; end
                else if (nib[2]) begin h++; g += 5; p += 50; end
                else if (nib[1]) begin h++; g += 2; p += 20; end
                else m++;
            end
        end
        m_prev = j;
        if (!m_failed) begin
            nl = m_life + g - 20 * m;
            if (nl < 0) nl = 0;
            if (nl > 320) nl = 320;
            m_life  = nl;
            m_score = (m_score + p > 1048575) ? 1048575 : m_score + p;
            if (m > 0) m_combo = 0;
            else m_combo = (m_combo + h > 255) ? 255 : m_combo + h;
            if (m_combo > m_max) m_max = m_combo;
            if (nl == 0) m_failed = 1;
        end
    endtask

    function automatic bit model_bar(input int sx, input int sy);
        return (sx >= 10) && (sx <= 20) && (sy <= 330) && (sy >= 331 - m_life);
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".life"},  u_if.life_o, m_life);
        chk({tag, ".score"}, u_if.score_o, m_score);
        chk({tag, ".combo"}, u_if.combo_o, m_combo);
        chk({tag, ".max"},   u_if.max_combo_o, m_max);
        chk({tag, ".failed"}, u_if.failed_o, m_failed);
        chk({tag, ".bar"},   u_if.life_bar_o, model_bar(int'(u_if.sx_i), int'(u_if.sy_i)));
    endtask

    task automatic cyc(input bit clr, input logic [15:0] j, input string tag);
        u_if.clear_i = clr;
        u_if.judge_i = j;
        @(posedge clk);
        model_clk(clr, j);
        #1;
        compare_model(tag);
    endtask

    task automatic strobe(input logic [15:0] j, input string tag);
        cyc(1'b0, j, tag);
        cyc(1'b0, 16'h0000, tag);
    endtask

    typedef struct {
        bit          clr;
        logic [15:0] j;
        int          life, score, combo, maxc;
        bit          failed;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input bit c, input logic [15:0] j, input int l,
                                input int s, input int cb, input int mx, input bit f);
        vec_t v;
        v.clr = c; v.j = j; v.life = l; v.score = s; v.combo = cb; v.maxc = mx; v.failed = f;
        return v;
    endfunction

    initial begin
        logic [15:0] rj;
        logic [3:0]  nib;
        int          r;

        tv.push_back(mk(0, 16'h0008, 168, 100, 1, 1, 0));
        for (int i = 0; i < 4; i++) tv.push_back(mk(0, 16'h0008, 168, 100, 1, 1, 0));
        tv.push_back(mk(0, 16'h0000, 168, 100, 1, 1, 0));
        tv.push_back(mk(0, 16'h1248, 163, 270, 0, 1, 0));
        tv.push_back(mk(0, 16'h0000, 163, 270, 0, 1, 0));
        tv.push_back(mk(1, 16'h0000, 160, 0, 0, 0, 0));
        tv.push_back(mk(0, 16'h1248, 155, 170, 0, 0, 0));
        tv.push_back(mk(0, 16'h0000, 155, 170, 0, 0, 0));
        tv.push_back(mk(0, 16'h00A0, 155, 170, 0, 0, 0));
        tv.push_back(mk(0, 16'h00A0, 155, 170, 0, 0, 0));
        tv.push_back(mk(0, 16'h0000, 155, 170, 0, 0, 0));
        tv.push_back(mk(0, 16'h0040, 160, 220, 1, 1, 0));
        tv.push_back(mk(0, 16'h0000, 160, 220, 1, 1, 0));
        tv.push_back(mk(1, 16'h0008, 160, 0, 0, 0, 0));
        tv.push_back(mk(0, 16'h0000, 160, 0, 0, 0, 0));

        rst = 1'b1;
        u_if.clear_i = 1'b0; u_if.judge_i = '0;
        u_if.sx_i = 10'd15;  u_if.sy_i = 10'd171;
        model_reset();
        #12;
        chk("rst.life", u_if.life_o, 160);
        chk("rst.score", u_if.score_o, 0);
        chk("rst.combo", u_if.combo_o, 0);
        chk("rst.max", u_if.max_combo_o, 0);
        chk("rst.failed", u_if.failed_o, 0);
        chk("rst.bar_top_row", u_if.life_bar_o, 1);
        u_if.sy_i = 10'd170; #1;
        chk("rst.bar_above", u_if.life_bar_o, 0);
        u_if.sy_i = 10'd200;
        rst = 1'b0;

        foreach (tv[i]) begin
            cyc(tv[i].clr, tv[i].j, "tbl");
            chk($sformatf("tbl%0d.life", i), u_if.life_o, tv[i].life);
            chk($sformatf("tbl%0d.score", i), u_if.score_o, tv[i].score);
            chk($sformatf("tbl%0d.combo", i), u_if.combo_o, tv[i].combo);
            chk($sformatf("tbl%0d.max", i), u_if.max_combo_o, tv[i].maxc);
            chk($sformatf("tbl%0d.failed", i), u_if.failed_o, tv[i].failed);
        end

        // life clamp at ceiling and full-height bar
        cyc(1'b1, 16'h0000, "clamp");
        for (int i = 0; i < 31; i++) strobe(16'h0004, "clamp");
        chk("clamp.pre", u_if.life_o, 315);
        cyc(1'b0, 16'h0088, "clamp");
        chk("clamp.life", u_if.life_o, 320);
        cyc(1'b0, 16'h0000, "clamp");
        for (int x = 9; x <= 21; x += 1) begin
            if (x == 9 || x == 10 || x == 20 || x == 21) begin
                for (int y = 0; y <= 340; y++) begin
                    u_if.sx_i = 10'(x); u_if.sy_i = 10'(y); #1;
                    chk($sformatf("bar_full x%0d y%0d", x, y), u_if.life_bar_o,
                        (x >= 10 && x <= 20 && y >= 11 && y <= 330) ? 1 : 0);
                end
            end
        end
        u_if.sx_i = 10'd15; u_if.sy_i = 10'd330;

        // drain to zero: fail is sticky and freezes the meter
        cyc(1'b1, 16'h0000, "fail");
        for (int i = 0; i < 7; i++) strobe(16'h0001, "fail");
        for (int i = 0; i < 2; i++) strobe(16'h0004, "fail");
        chk("fail.pre", u_if.life_o, 30);
        cyc(1'b0, 16'h0011, "fail");
        chk("fail.life", u_if.life_o, 0);
        chk("fail.flag", u_if.failed_o, 1);
        chk("fail.combo", u_if.combo_o, 0);
        for (int y = 0; y <= 340; y += 10) begin
            u_if.sy_i = 10'(y); #1;
            chk($sformatf("fail.bar y%0d", y), u_if.life_bar_o, 0);
        end
        u_if.sy_i = 10'd330;
        cyc(1'b0, 16'h0000, "fail");
        strobe(16'h0008, "fail");
        chk("fail.after_life", u_if.life_o, 0);
        chk("fail.after_score", u_if.score_o, 100);
        chk("fail.after_combo", u_if.combo_o, 0);
        chk("fail.after_flag", u_if.failed_o, 1);

        // combo saturation, then clear beats a simultaneous hit
        cyc(1'b1, 16'h0000, "sat");
        for (int i = 0; i < 255; i++) strobe(16'h0008, "sat");
        chk("sat.combo", u_if.combo_o, 255);
        strobe(16'h0080, "sat");
        chk("sat.combo_hold", u_if.combo_o, 255);
        chk("sat.max", u_if.max_combo_o, 255);
        chk("sat.score", u_if.score_o, 25600);
        cyc(1'b1, 16'h0800, "sat");
        chk("clr.life", u_if.life_o, 160);
        chk("clr.score", u_if.score_o, 0);
        chk("clr.combo", u_if.combo_o, 0);
        chk("clr.max", u_if.max_combo_o, 0);
        chk("clr.failed", u_if.failed_o, 0);
        cyc(1'b0, 16'h0000, "clr");

        // randomized strobes against the reference model
        for (int it = 0; it < 3000; it++) begin
            rj = '0;
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 9);
                case (r)
                    5: nib = 4'b0001;
                    6: nib = 4'b0100;
                    7: nib = 4'b1000;
                    8: nib = 4'b0010;
                    9: nib = 4'($urandom_range(0, 15));
                    default: nib = 4'b0000;
                endcase
                rj[4*k +: 4] = nib;
            end
            u_if.sx_i = 10'($urandom_range(0, 30));
            u_if.sy_i = 10'($urandom_range(0, 400));
            cyc($urandom_range(0, 63) == 0, rj, "rnd");
            if (it % 97 == 50) begin
                rst = 1'b1;
                #2;
                model_reset();
                compare_model("async_rst");
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
